ctrl_pipe_unit: RTL and testbench
=================================

CTRL_PIPE_UNIT -- requirements
Module: ctrl_pipe_unit

Interface
REQ-001 SHALL have parameter EN_M, default 1, meaning: 1 decodes M-extension (R-type, Funct7=7'b0000001) as multi-cycle.
REQ-002 SHALL have parameter EN_JUMP, default 1, meaning: 1 decodes JAL/JALR; 0 treats them as illegal.
REQ-003 SHALL have parameter MULDIV_LAT, default 4, range 2..15, meaning: EX-stage cycles occupied by a mul/div.
REQ-004 Ports:
  clk        in   1  rising-edge clock
  rst_n      in   1  asynchronous active-low reset
  Opcode     in   7  ID-stage instruction[6:0]
  Funct7     in   7  ID-stage instruction[31:25]
  Rs1, Rs2   in   5  ID-stage source registers
  Ex_Rd      in   5  destination register of instruction in EX
  BranchTaken in  1  EX-stage branch/jump resolved taken
  Ex_ALUSrc, Ex_MemtoReg, Ex_RegWrite, Ex_MemRead, Ex_MemWrite, Ex_Branch, Ex_Jump, Ex_MulDiv  out 1 each  registered ID/EX control
  Ex_ALUOp   out  2  registered ALU op class
  Stall      out  1  hold PC and IF/ID
  Flush_IfId out  1  zero IF/ID
  Busy       out  1  mul/div in progress
  Illegal    out  1  ID opcode unsupported (combinational)
REQ-005 Only one clock (clk) and reset (rst_n, asynchronous, active-low) SHALL exist.

Function
REQ-006 Decode (combinational, pre-register): R 0110011 -> RegWrite, ALUOp=10, MulDiv=(EN_M & Funct7==0000001); I 0010011 -> ALUSrc, RegWrite, ALUOp=10; LW 0000011 -> ALUSrc, MemtoReg, RegWrite, MemRead, ALUOp=00; SW 0100011 -> ALUSrc, MemWrite, ALUOp=00; BR 1100011 -> Branch, ALUOp=01; LUI 0110111 -> ALUSrc, RegWrite, ALUOp=11; JAL 1101111 -> RegWrite, Jump, ALUOp=00; JALR 1100111 -> ALUSrc, RegWrite, Jump, ALUOp=00.
REQ-007 Any other opcode (or JAL/JALR with EN_JUMP=0) SHALL decode to all-zero bundle and assert Illegal.
REQ-008 Ex_* SHALL load the decoded bundle every rising edge, with latency 1, unless bubble or hold applies.
REQ-009 Load-use hazard = Ex_MemRead & Ex_Rd!=0 & (Ex_Rd==Rs1 | Ex_Rd==Rs2); when true, Stall=1 and Ex_* loads all-zero bundle (bubble).
REQ-010 Taken branch: BranchTaken=1 SHALL set Flush_IfId=1 and load bubble into Ex_*; flush overrides load-use stall (Stall=0).
REQ-011 FSM states IDLE, MULDIV; 4-bit counter cnt.
REQ-012 IDLE -> MULDIV on clock edge when Ex_MulDiv=1 in IDLE, cnt <= MULDIV_LAT-2.
REQ-013 In MULDIV: Stall=1, Busy=1, Ex_* held unchanged, BranchTaken ignored, load-use check suppressed; cnt decrements each cycle; at cnt==0 -> IDLE next edge.
REQ-014 On the cycle after MULDIV exits, Ex_* SHALL load the decoded bundle normally (total EX occupancy = MULDIV_LAT cycles).
REQ-015 Back-to-back mul/div SHALL re-enter MULDIV with no extra idle cycle beyond the 1 normal load cycle.
REQ-016 Stall, Flush_IfId, Busy, Illegal SHALL be combinational from inputs, Ex_*, and FSM state.

Reset
REQ-017 rst_n=0 SHALL asynchronously clear all Ex_* to 0, FSM to IDLE, cnt to 0.
REQ-018 Reset mid-MULDIV SHALL abort immediately; Busy and Stall deassert while rst_n=0.
REQ-019 First edge after rst_n rises SHALL load decoded bundle normally.

Structure
REQ-020 Opcode constants, ALUOp encodings, ctrl bundle packed struct, and FSM state enum SHALL live in shared package riscv_ctrl_pkg.
REQ-021 Combinational decode SHALL be a sub-module ctrl_decoder (Opcode, Funct7 -> bundle, Illegal); hazard logic, FSM, and ID/EX register in the top.

Verification
REQ-022 Reset: rst_n=0 mid-run -> all Ex_*=0, Busy=0 same cycle, no clock needed.
REQ-023 LW x5 in EX (Ex_MemRead=1, Ex_Rd=5), ID ADD rs1=5 -> Stall=1; next edge Ex_RegWrite=0, Ex_ALUOp=00; Ex_Rd=0 case -> Stall=0.
REQ-024 Load-use condition plus BranchTaken=1 -> Stall=0, Flush_IfId=1, next Ex_* all zero.
REQ-025 MUL (0110011, Funct7=0000001), MULDIV_LAT=4 -> Ex_MulDiv=1 for 4 consecutive cycles, Busy=1 for cycles 2-4, Stall=1 during Busy; EN_M=0 -> Ex_MulDiv=0, no Busy.
REQ-026 Opcode 0001111 -> Illegal=1, next Ex_* zero; JAL with EN_JUMP=0 -> Illegal=1; EN_JUMP=1 -> Ex_Jump=1, Ex_RegWrite=1.
REQ-027 All eight opcodes sequentially, no hazards -> Ex_* match REQ-006 table one cycle later.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared opcode constants, ALU-op classes, control bundle and FSM state for the ID/EX controller.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LW   = 7'b0000011;
  localparam logic [6:0] OPC_SW   = 7'b0100011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  localparam logic [6:0] FUNCT7_M = 7'b0000001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LUI   = 2'b11;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       mul_div;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  typedef enum logic [0:0] {
    StIdle,
    StMulDiv
  } md_state_e;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode decoder producing the ID-stage control bundle.
module ctrl_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter bit EN_M    = 1'b1,
  parameter bit EN_JUMP = 1'b1
) (
  input  logic [6:0] Opcode,
  input  logic [6:0] Funct7,
  output ctrl_t      Ctrl,
  output logic       Illegal
);

  // Map each supported opcode to its control bundle; anything else is illegal and a no-op.
  always_comb begin
    Ctrl    = CTRL_NOP;
    Illegal = 1'b0;
    case (Opcode)
      OPC_R: begin
        Ctrl.reg_write = 1'b1;
        Ctrl.alu_op    = ALUOP_FUNCT;
        Ctrl.mul_div   = EN_M && (Funct7 == FUNCT7_M);
      end
      OPC_I: begin
        Ctrl.alu_src   = 1'b1;
        Ctrl.reg_write = 1'b1;
        Ctrl.alu_op    = ALUOP_FUNCT;
      end
      OPC_LW: begin
        Ctrl.alu_src    = 1'b1;
        Ctrl.mem_to_reg = 1'b1;
        Ctrl.reg_write  = 1'b1;
        Ctrl.mem_read   = 1'b1;
        Ctrl.alu_op     = ALUOP_ADD;
      end
      OPC_SW: begin
        Ctrl.alu_src   = 1'b1;
        Ctrl.mem_write = 1'b1;
        Ctrl.alu_op    = ALUOP_ADD;
      end
      OPC_BR: begin
        Ctrl.branch = 1'b1;
        Ctrl.alu_op = ALUOP_BR;
      end
      OPC_LUI: begin
        Ctrl.alu_src   = 1'b1;
        Ctrl.reg_write = 1'b1;
        Ctrl.alu_op    = ALUOP_LUI;
      end
      OPC_JAL: begin
        if (EN_JUMP) begin
          Ctrl.reg_write = 1'b1;
          Ctrl.jump      = 1'b1;
          Ctrl.alu_op    = ALUOP_ADD;
        end else begin
          Illegal = 1'b1;
        end
      end
      OPC_JALR: begin
        if (EN_JUMP) begin
          Ctrl.alu_src   = 1'b1;
          Ctrl.reg_write = 1'b1;
          Ctrl.jump      = 1'b1;
          Ctrl.alu_op    = ALUOP_ADD;
        end else begin
          Illegal = 1'b1;
        end
      end
      default: Illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// ID/EX control register with load-use / branch hazard handling and a multi-cycle mul/div hold.
module ctrl_pipe_unit
  import riscv_ctrl_pkg::*;
#(
  parameter bit          EN_M       = 1'b1,
  parameter bit          EN_JUMP    = 1'b1,
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Opcode,
  input  logic [6:0] Funct7,
  input  logic [4:0] Rs1,
  input  logic [4:0] Rs2,
  input  logic [4:0] Ex_Rd,
  input  logic       BranchTaken,
  output logic       Ex_ALUSrc,
  output logic       Ex_MemtoReg,
  output logic       Ex_RegWrite,
  output logic       Ex_MemRead,
  output logic       Ex_MemWrite,
  output logic       Ex_Branch,
  output logic       Ex_Jump,
  output logic       Ex_MulDiv,
  output logic [1:0] Ex_ALUOp,
  output logic       Stall,
  output logic       Flush_IfId,
  output logic       Busy,
  output logic       Illegal
);

  // The first EX cycle is spent in StIdle, so the counter covers the remaining cycles minus one.
  localparam logic [3:0] CntInit = 4'(MULDIV_LAT - 2);

  ctrl_t      w_dec;
  logic       w_illegal;
  ctrl_t      r_ex;
  md_state_e  r_state;
  logic [3:0] r_cnt;
  logic       w_in_md;
  logic       w_load_use;
  logic       w_hold;
  logic       w_bubble;

  ctrl_decoder #(
    .EN_M    (EN_M),
    .EN_JUMP (EN_JUMP)
  ) u_decoder (
    .Opcode  (Opcode),
    .Funct7  (Funct7),
    .Ctrl    (w_dec),
    .Illegal (w_illegal)
  );

  assign w_in_md    = (r_state == StMulDiv);
  assign w_load_use = r_ex.mem_read && (Ex_Rd != 5'd0) && ((Ex_Rd == Rs1) || (Ex_Rd == Rs2));
  // Keep the mul/div in EX from its first cycle until the last counted cycle.
  assign w_hold     = w_in_md ? (r_cnt != 4'd0) : r_ex.mul_div;
  assign w_bubble   = !w_in_md && (BranchTaken || w_load_use);

  assign Flush_IfId = !w_in_md && BranchTaken;
  assign Stall      = w_in_md || (w_load_use && !BranchTaken);
  assign Busy       = w_in_md;
  assign Illegal    = w_illegal;

  // ID/EX control register: hold during mul/div, bubble on hazards, else take the decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex <= CTRL_NOP;
    end else if (w_hold) begin
      r_ex <= r_ex;
    end else if (w_bubble) begin
      r_ex <= CTRL_NOP;
    end else begin
      r_ex <= w_dec;
    end
  end

  // Mul/div occupancy FSM with down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        StIdle: begin
          if (r_ex.mul_div) begin
            r_state <= StMulDiv;
            r_cnt   <= CntInit;
          end
        end
        StMulDiv: begin
          if (r_cnt == 4'd0) begin
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign Ex_ALUSrc   = r_ex.alu_src;
  assign Ex_MemtoReg = r_ex.mem_to_reg;
  assign Ex_RegWrite = r_ex.reg_write;
  assign Ex_MemRead  = r_ex.mem_read;
  assign Ex_MemWrite = r_ex.mem_write;
  assign Ex_Branch   = r_ex.branch;
  assign Ex_Jump     = r_ex.jump;
  assign Ex_MulDiv   = r_ex.mul_div;
  assign Ex_ALUOp    = r_ex.alu_op;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Scoreboard bench: default-parameter DUT (a) and EN_M=0/EN_JUMP=0 DUT (b) share stimulus.
module tb_ctrl_pipe_unit;

  // Opcodes
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_FNC  = 7'b0001111;
  localparam logic [6:0] F7_0    = 7'b0000000;
  localparam logic [6:0] F7_M    = 7'b0000001;

  // Expected EX bundles {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,MulDiv,ALUOp}
  localparam logic [9:0] Z     = 10'b0000000000;
  localparam logic [9:0] ADDE  = 10'b0010000010;
  localparam logic [9:0] MULE  = 10'b0010000110;
  localparam logic [9:0] IE    = 10'b1010000010;
  localparam logic [9:0] LWE   = 10'b1111000000;
  localparam logic [9:0] SWE   = 10'b1000100000;
  localparam logic [9:0] BRE   = 10'b0000010001;
  localparam logic [9:0] LUIE  = 10'b1010000011;
  localparam logic [9:0] JALE  = 10'b0010001000;
  localparam logic [9:0] JALRE = 10'b1010001000;

  // Flags {Stall, Flush_IfId, Busy, Illegal}
  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_ILL  = 4'b0001;
  localparam logic [3:0] F_STL  = 4'b1000;
  localparam logic [3:0] F_FLS  = 4'b0100;
  localparam logic [3:0] F_BSY  = 4'b1010;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic [6:0] f7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] exrd;
    logic       bt;
    logic [9:0] a_ex;
    logic [3:0] a_fl;
    logic [9:0] b_ex;
    logic [3:0] b_fl;
  } vec_t;

  typedef struct {
    int         idx;
    logic [9:0] a_ex;
    logic [3:0] a_fl;
    logic [9:0] b_ex;
    logic [3:0] b_fl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = OP_R;
  logic [6:0] funct7 = F7_0;
  logic [4:0] rs1 = 5'd1;
  logic [4:0] rs2 = 5'd1;
  logic [4:0] ex_rd = 5'd0;
  logic       branch_taken = 1'b0;

  logic a_alusrc, a_memtoreg, a_regwrite, a_memread, a_memwrite, a_branch, a_jump, a_muldiv;
  logic b_alusrc, b_memtoreg, b_regwrite, b_memread, b_memwrite, b_branch, b_jump, b_muldiv;
  logic [1:0] a_aluop, b_aluop;
  logic a_stall, a_flush, a_busy, a_illegal;
  logic b_stall, b_flush, b_busy, b_illegal;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  ctrl_pipe_unit #(
    .EN_M       (1'b1),
    .EN_JUMP    (1'b1),
    .MULDIV_LAT (4)
  ) u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .Opcode      (opcode),
    .Funct7      (funct7),
    .Rs1         (rs1),
    .Rs2         (rs2),
    .Ex_Rd       (ex_rd),
    .BranchTaken (branch_taken),
    .Ex_ALUSrc   (a_alusrc),
    .Ex_MemtoReg (a_memtoreg),
    .Ex_RegWrite (a_regwrite),
    .Ex_MemRead  (a_memread),
    .Ex_MemWrite (a_memwrite),
    .Ex_Branch   (a_branch),
    .Ex_Jump     (a_jump),
    .Ex_MulDiv   (a_muldiv),
    .Ex_ALUOp    (a_aluop),
    .Stall       (a_stall),
    .Flush_IfId  (a_flush),
    .Busy        (a_busy),
    .Illegal     (a_illegal)
  );

  ctrl_pipe_unit #(
    .EN_M       (1'b0),
    .EN_JUMP    (1'b0),
    .MULDIV_LAT (4)
  ) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .Opcode      (opcode),
    .Funct7      (funct7),
    .Rs1         (rs1),
    .Rs2         (rs2),
    .Ex_Rd       (ex_rd),
    .BranchTaken (branch_taken),
    .Ex_ALUSrc   (b_alusrc),
    .Ex_MemtoReg (b_memtoreg),
    .Ex_RegWrite (b_regwrite),
    .Ex_MemRead  (b_memread),
    .Ex_MemWrite (b_memwrite),
    .Ex_Branch   (b_branch),
    .Ex_Jump     (b_jump),
    .Ex_MulDiv   (b_muldiv),
    .Ex_ALUOp    (b_aluop),
    .Stall       (b_stall),
    .Flush_IfId  (b_flush),
    .Busy        (b_busy),
    .Illegal     (b_illegal)
  );

  task automatic add(input logic rst, input logic [6:0] op, input logic [6:0] f7,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                     input logic bt, input logic [9:0] aex, input logic [3:0] afl,
                     input logic [9:0] bex, input logic [3:0] bfl);
    vec_t v;
    v.rst  = rst;
    v.op   = op;
    v.f7   = f7;
    v.rs1  = r1;
    v.rs2  = r2;
    v.exrd = rd;
    v.bt   = bt;
    v.a_ex = aex;
    v.a_fl = afl;
    v.b_ex = bex;
    v.b_fl = bfl;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [9:0] act,
                     input logic [9:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: got %b, required %b", name, idx, act, req);
    end
  endtask

  // Monitor: every cycle with an expectation pending, compare both DUTs mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("a_ex", mon_e.idx, {a_alusrc, a_memtoreg, a_regwrite, a_memread, a_memwrite,
          a_branch, a_jump, a_muldiv, a_aluop}, mon_e.a_ex);
      chk("a_flags", mon_e.idx, {6'd0, a_stall, a_flush, a_busy, a_illegal},
          {6'd0, mon_e.a_fl});
      chk("b_ex", mon_e.idx, {b_alusrc, b_memtoreg, b_regwrite, b_memread, b_memwrite,
          b_branch, b_jump, b_muldiv, b_aluop}, mon_e.b_ex);
      chk("b_flags", mon_e.idx, {6'd0, b_stall, b_flush, b_busy, b_illegal},
          {6'd0, mon_e.b_fl});
    end
  end

  initial begin
    //  rst op       f7    rs1 rs2 exrd bt  a_ex   a_fl    b_ex   b_fl
    add(0, OP_R,    F7_0, 1,  1,  0,   0,  Z,     F_NONE, Z,     F_NONE); // in reset
    add(1, OP_R,    F7_0, 1,  1,  0,   0,  Z,     F_NONE, Z,     F_NONE);
    add(1, OP_I,    F7_0, 1,  1,  0,   0,  ADDE,  F_NONE, ADDE,  F_NONE);
    add(1, OP_LW,   F7_0, 1,  1,  0,   0,  IE,    F_NONE, IE,    F_NONE);
    add(1, OP_SW,   F7_0, 0,  0,  0,   0,  LWE,   F_NONE, LWE,   F_NONE); // Ex_Rd=0: no stall
    add(1, OP_BR,   F7_0, 1,  1,  0,   0,  SWE,   F_NONE, SWE,   F_NONE);
    add(1, OP_LUI,  F7_0, 1,  1,  0,   0,  BRE,   F_NONE, BRE,   F_NONE);
    add(1, OP_JAL,  F7_0, 1,  1,  0,   0,  LUIE,  F_NONE, LUIE,  F_ILL);
    add(1, OP_JALR, F7_0, 1,  1,  0,   0,  JALE,  F_NONE, Z,     F_ILL);
    add(1, OP_FNC,  F7_0, 1,  1,  0,   0,  JALRE, F_ILL,  Z,     F_ILL);
    add(1, OP_R,    F7_0, 1,  1,  0,   0,  Z,     F_NONE, Z,     F_NONE);
    add(1, OP_LW,   F7_0, 1,  1,  0,   0,  ADDE,  F_NONE, ADDE,  F_NONE);
    add(1, OP_R,    F7_0, 5,  1,  5,   0,  LWE,   F_STL,  LWE,   F_STL);  // load-use rs1
    add(1, OP_R,    F7_0, 1,  1,  5,   0,  Z,     F_NONE, Z,     F_NONE); // bubble
    add(1, OP_LW,   F7_0, 1,  1,  0,   0,  ADDE,  F_NONE, ADDE,  F_NONE);
    add(1, OP_R,    F7_0, 1,  7,  7,   1,  LWE,   F_FLS,  LWE,   F_FLS);  // flush wins
    add(1, OP_I,    F7_0, 1,  1,  0,   0,  Z,     F_NONE, Z,     F_NONE);
    add(1, OP_LW,   F7_0, 1,  1,  0,   0,  IE,    F_NONE, IE,    F_NONE);
    add(1, OP_R,    F7_0, 1,  9,  9,   0,  LWE,   F_STL,  LWE,   F_STL);  // load-use rs2
    add(1, OP_R,    F7_M, 1,  1,  0,   0,  Z,     F_NONE, Z,     F_NONE); // MUL
    add(1, OP_R,    F7_0, 1,  1,  0,   0,  MULE,  F_NONE, ADDE,  F_NONE); // mul cycle 1
    add(1, OP_I,    F7_0, 1,  1,  0,   0,  MULE,  F_BSY,  ADDE,  F_NONE); // cycle 2
    add(1, OP_BR,   F7_0, 1,  1,  0,   1,  MULE,  F_BSY,  IE,    F_FLS);  // branch ignored
    add(1, OP_LW,   F7_0, 1,  1,  0,   0,  MULE,  F_BSY,  Z,     F_NONE); // cycle 4
    add(1, OP_R,    F7_M, 1,  1,  0,   0,  LWE,   F_NONE, LWE,   F_NONE);
    add(1, OP_R,    F7_M, 1,  1,  0,   0,  MULE,  F_NONE, ADDE,  F_NONE);
    add(1, OP_R,    F7_0, 1,  1,  0,   0,  MULE,  F_BSY,  ADDE,  F_NONE);
    add(1, OP_R,    F7_0, 1,  1,  0,   0,  MULE,  F_BSY,  ADDE,  F_NONE);
    add(1, OP_R,    F7_M, 1,  1,  0,   0,  MULE,  F_BSY,  ADDE,  F_NONE);
    add(1, OP_R,    F7_0, 1,  1,  0,   0,  MULE,  F_NONE, ADDE,  F_NONE); // back-to-back
    add(1, OP_R,    F7_0, 1,  1,  0,   0,  MULE,  F_BSY,  ADDE,  F_NONE);
    add(0, OP_R,    F7_0, 1,  1,  0,   0,  Z,     F_NONE, Z,     F_NONE); // async abort
    add(1, OP_JAL,  F7_0, 1,  1,  0,   0,  Z,     F_NONE, Z,     F_ILL);
    add(1, OP_R,    F7_0, 1,  1,  0,   0,  JALE,  F_NONE, Z,     F_NONE);
    add(1, OP_R,    F7_0, 1,  1,  0,   0,  ADDE,  F_NONE, ADDE,  F_NONE);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      @(posedge clk);
      #1;
      rst_n        = vecs[i].rst;
      opcode       = vecs[i].op;
      funct7       = vecs[i].f7;
      rs1          = vecs[i].rs1;
      rs2          = vecs[i].rs2;
      ex_rd        = vecs[i].exrd;
      branch_taken = vecs[i].bt;
      e.idx  = i;
      e.a_ex = vecs[i].a_ex;
      e.a_fl = vecs[i].a_fl;
      e.b_ex = vecs[i].b_ex;
      e.b_fl = vecs[i].b_fl;
      sb.push_back(e);
    end

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
